bomb_controller: RTL and testbench
==================================

Name: bomb_controller

Overview:
- Bomb and explosion stage. It consumes the player position and the debounced centre button from the bomberman sprite block, and the VGA scan position from the display controller.
- It owns one bomb: placement, fuse countdown, explosion cross and cleanup.
- It produces the bomb and explosion pixel colour/enable pairs for the top-level pixel priority mux.
- It also produces a hit flag that feeds the top-level game-over logic.

Parameters:
- FUSE_CYCLES, 300_000_000: clock cycles from placement to detonation (3 s at 100 MHz).
- EXPLODE_CYCLES, 50_000_000: clock cycles the explosion stays visible and lethal.
- RANGE, 1: explosion arm length in tiles, in each of the 4 directions.
- H_OFFSET, 144: hCount of the first visible column.
- V_OFFSET, 35: vCount of the first visible row.
- TILE_LOG2, 5: tile size is 32x32 px; the grid is 20 cols x 15 rows.
- BOMB_RGB, 12'h222: bomb colour.
- EXPLOSION_RGB, 12'hF80: explosion colour.

Ports:
- clk  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-high reset
- C  in  1  debounced centre button (level); a rising edge requests placement
- b_x  in  10  bomberman sprite top-left x, in hCount frame
- b_y  in  10  bomberman sprite top-left y, in vCount frame
- game_over  in  1  freezes all timers while high
- v_x  in  10  current hCount
- v_y  in  10  current vCount
- bomb_on  out  1  current pixel belongs to the bomb
- bomb_rgb  out  12  bomb pixel colour
- explosion_on  out  1  current pixel belongs to the explosion cross
- explosion_rgb  out  12  explosion pixel colour
- bomb_active  out  1  FSM is in ARMED
- explode_active  out  1  FSM is in EXPLODE
- bomberman_hit  out  1  player centre tile lies inside the live explosion

Behaviour:
- Reset values:
  - FSM = IDLE; counters = 0; stored tile = (0,0).
  - bomb_on, explosion_on, bomb_active, explode_active and bomberman_hit = 0.
  - bomb_rgb = 0; explosion_rgb = 0.
- Edge detect: c_q is C registered. place_req = C & ~c_q. c_q resets to 0.
- Player tile: col = (b_x - H_OFFSET + 16) >> TILE_LOG2; row = (b_y - V_OFFSET + 16) >> TILE_LOG2.
  - Subtraction is 10-bit unsigned.
  - Col is clamped to 0..19 and row to 0..14.
- FSM:
  - IDLE: on place_req, latch (col,row) into bomb_col/bomb_row, clear the counter, go to ARMED.
  - ARMED: counter increments each cycle. When counter == FUSE_CYCLES-1, clear it and go to EXPLODE. place_req is ignored.
  - EXPLODE: counter increments. When counter == EXPLODE_CYCLES-1, clear it and go to IDLE. place_req is ignored.
  - place_req in the same cycle as EXPLODE->IDLE is dropped; a new edge is required.
- game_over high: counters and state hold. Pixel outputs keep rendering the current state.
- Reset mid-ARMED or mid-EXPLODE: the bomb vanishes immediately (async), and the FSM returns to IDLE.
- Pixel path, all outputs registered (1-cycle latency, matching the registered VGA mux in top):
  - Pixel tile: pc = (v_x - H_OFFSET) >> TILE_LOG2; pr = (v_y - V_OFFSET) >> TILE_LOG2.
  - Pixel offset within the tile: px = low TILE_LOG2 bits.
  - visible = v_x in [H_OFFSET, H_OFFSET+639] and v_y in [V_OFFSET, V_OFFSET+479]. Outside visible, both enables are 0.
  - bomb_on = ARMED & visible & pc==bomb_col & pr==bomb_row & px,py both in [4,27]. This gives a 24x24 square inset in the tile.
  - explosion_on = EXPLODE & visible & pixel tile in the cross:
    - pr==bomb_row and |pc-bomb_col| <= RANGE, or
    - pc==bomb_col and |pr-bomb_row| <= RANGE.
    - Cells outside 0..19 / 0..14 never match, so there is no wrap-around at grid edges.
  - bomb_rgb = BOMB_RGB when bomb_on, else 0. explosion_rgb = EXPLOSION_RGB when explosion_on, else 0.
- bomberman_hit: registered; = EXPLODE & (player centre tile is in the cross). Level output, 0 outside EXPLODE.
- bomb_active / explode_active: registered decodes of state.
- Widths:
  - Counter width = clog2(max(FUSE_CYCLES, EXPLODE_CYCLES)).
  - Tile coordinates are 5 bits.
  - Distance compare uses signed 6-bit differences.

Decomposition:
- Shared package bomberman_pkg:
  - FSM state typedef (IDLE, ARMED, EXPLODE).
  - TILE_LOG2, GRID_COLS=20, GRID_ROWS=15, H_OFFSET, V_OFFSET.
  - The colour constants.
- One sub-module: tile_cross_match.
  - Pure combinational: (tile_col, tile_row, centre_col, centre_row, RANGE) -> in_cross.
  - Instantiated twice, once for the pixel tile and once for the player tile.

Test Plan:
- Use FUSE_CYCLES=20 and EXPLODE_CYCLES=10 in the bench.
- Reset, then C rising with b_x=176, b_y=67 (tile 1,1) -> next cycle bomb_active=1. bomb_on=1 exactly for v_x 180..203, v_y 71..94, one cycle after the scan position.
- Hold in ARMED -> explode_active rises exactly 20 cycles after entry. explosion_on covers tiles (0..2,1) and (1,0..2) only. Return to IDLE after 10 cycles.
- Bomb at tile (0,0) -> the cross renders only (0,0), (1,0), (0,1). Pixels at v_x<144 give explosion_on=0.
- Second C edge during ARMED, and C held high across EXPLODE->IDLE -> no re-placement. A fresh edge in IDLE places.
- Player centre in tile (2,1) during EXPLODE of a bomb at (1,1) -> bomberman_hit=1. Move to (2,2) -> 0.
- game_over=1 for 15 cycles mid-ARMED -> detonation delayed by 15 cycles.
- Async reset mid-EXPLODE -> all outputs are 0 without waiting for a clock edge.

Source files
------------

// File: rtl/bomberman_pkg.sv
// Shared constants and types for the bomberman play-field blocks.
package bomberman_pkg;

  localparam int TILE_LOG2 = 5;
  localparam int TILE_W    = 5;
  localparam int GRID_COLS = 20;
  localparam int GRID_ROWS = 15;
  localparam int H_OFFSET  = 144;
  localparam int V_OFFSET  = 35;

  localparam logic [11:0] BOMB_COLOR      = 12'h222;
  localparam logic [11:0] EXPLOSION_COLOR = 12'hF80;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    EXPLODE = 2'd2
  } bomb_state_e;

endpackage

// File: rtl/tile_cross_match.sv
// Combinational test: does a tile fall inside the plus-shaped blast centred on a tile.
module tile_cross_match
  import bomberman_pkg::*;
#(
  parameter int RANGE = 1
) (
  input  logic [TILE_W-1:0] tile_col_i,
  input  logic [TILE_W-1:0] tile_row_i,
  input  logic [TILE_W-1:0] centre_col_i,
  input  logic [TILE_W-1:0] centre_row_i,
  output logic              in_cross_o
);

  localparam logic signed [5:0] R = 6'(RANGE);

  logic signed [5:0] dc, dr, adc, adr;
  logic              in_grid;

  always_comb begin
    dc  = $signed({1'b0, tile_col_i}) - $signed({1'b0, centre_col_i});
    dr  = $signed({1'b0, tile_row_i}) - $signed({1'b0, centre_row_i});
    adc = dc[5] ? -dc : dc;
    adr = dr[5] ? -dr : dr;
    // Off-grid tiles never match, so arms are clipped rather than wrapped.
    in_grid    = (tile_col_i < TILE_W'(GRID_COLS)) && (tile_row_i < TILE_W'(GRID_ROWS));
    in_cross_o = in_grid &&
                 (((tile_row_i == centre_row_i) && (adc <= R)) ||
                  ((tile_col_i == centre_col_i) && (adr <= R)));
  end

endmodule

// File: rtl/bomb_controller.sv
// Single-bomb lifecycle (place, fuse, blast, clear) plus registered bomb/blast
// pixel enables and the player-hit flag.
module bomb_controller
  import bomberman_pkg::*;
#(
  parameter int          FUSE_CYCLES    = 300_000_000,
  parameter int          EXPLODE_CYCLES = 50_000_000,
  parameter int          RANGE          = 1,
  parameter logic [11:0] BOMB_RGB       = BOMB_COLOR,
  parameter logic [11:0] EXPLOSION_RGB  = EXPLOSION_COLOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        C,
  input  logic [9:0]  b_x,
  input  logic [9:0]  b_y,
  input  logic        game_over,
  input  logic [9:0]  v_x,
  input  logic [9:0]  v_y,
  output logic        bomb_on,
  output logic [11:0] bomb_rgb,
  output logic        explosion_on,
  output logic [11:0] explosion_rgb,
  output logic        bomb_active,
  output logic        explode_active,
  output logic        bomberman_hit
);

  localparam int CNT_MAX = (FUSE_CYCLES > EXPLODE_CYCLES) ? FUSE_CYCLES : EXPLODE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] FUSE_LAST = CNT_W'(FUSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXPL_LAST = CNT_W'(EXPLODE_CYCLES - 1);
  localparam logic [TILE_W-1:0] INSET_LO = TILE_W'(4);
  localparam logic [TILE_W-1:0] INSET_HI = TILE_W'((1 << TILE_LOG2) - 5);

  bomb_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TILE_W-1:0] bomb_col_q, bomb_col_d, bomb_row_q, bomb_row_d;
  logic              c_q, place_req;

  logic [9:0]        b_cx, b_cy, b_ct, b_rt;
  logic [TILE_W-1:0] p_col, p_row;
  logic [9:0]        v_dx, v_dy, pc_full, pr_full;
  logic [TILE_W-1:0] px, py;
  logic              visible, pix_in_cross, hit_in_cross;

  logic bomb_on_q, bomb_on_d, expl_on_q, expl_on_d, hit_q, hit_d;
  logic bomb_act_q, expl_act_q;
  logic [11:0] bomb_rgb_q, expl_rgb_q;

  assign place_req = C & ~c_q;

  // Player tile is taken at the sprite centre; 10-bit wrap of the subtraction
  // lands left/above-grid positions on the far clamp, which is accepted.
  always_comb begin
    b_cx  = b_x - 10'(H_OFFSET) + 10'd16;
    b_cy  = b_y - 10'(V_OFFSET) + 10'd16;
    b_ct  = b_cx >> TILE_LOG2;
    b_rt  = b_cy >> TILE_LOG2;
    p_col = (b_ct > 10'(GRID_COLS - 1)) ? TILE_W'(GRID_COLS - 1) : b_ct[TILE_W-1:0];
    p_row = (b_rt > 10'(GRID_ROWS - 1)) ? TILE_W'(GRID_ROWS - 1) : b_rt[TILE_W-1:0];
  end

  always_comb begin
    v_dx    = v_x - 10'(H_OFFSET);
    v_dy    = v_y - 10'(V_OFFSET);
    pc_full = v_dx >> TILE_LOG2;
    pr_full = v_dy >> TILE_LOG2;
    px      = v_dx[TILE_W-1:0];
    py      = v_dy[TILE_W-1:0];
    visible = (v_x >= 10'(H_OFFSET)) && (pc_full < 10'(GRID_COLS)) &&
              (v_y >= 10'(V_OFFSET)) && (pr_full < 10'(GRID_ROWS));
  end

  tile_cross_match #(.RANGE(RANGE)) u_pix_cross (
    .tile_col_i   (pc_full[TILE_W-1:0]),
    .tile_row_i   (pr_full[TILE_W-1:0]),
    .centre_col_i (bomb_col_q),
    .centre_row_i (bomb_row_q),
    .in_cross_o   (pix_in_cross)
  );

  tile_cross_match #(.RANGE(RANGE)) u_hit_cross (
    .tile_col_i   (p_col),
    .tile_row_i   (p_row),
    .centre_col_i (bomb_col_q),
    .centre_row_i (bomb_row_q),
    .in_cross_o   (hit_in_cross)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bomb_col_d = bomb_col_q;
    bomb_row_d = bomb_row_q;
    if (!game_over) begin
      case (state_q)
        IDLE: if (place_req) begin
          bomb_col_d = p_col;
          bomb_row_d = p_row;
          cnt_d      = '0;
          state_d    = ARMED;
        end
        ARMED: if (cnt_q == FUSE_LAST) begin
          cnt_d   = '0;
          state_d = EXPLODE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        EXPLODE: if (cnt_q == EXPL_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bomb_on_d = (state_q == ARMED) && visible &&
                (pc_full[TILE_W-1:0] == bomb_col_q) && (pr_full[TILE_W-1:0] == bomb_row_q) &&
                (px >= INSET_LO) && (px <= INSET_HI) && (py >= INSET_LO) && (py <= INSET_HI);
    expl_on_d = (state_q == EXPLODE) && visible && pix_in_cross;
    hit_d     = (state_q == EXPLODE) && hit_in_cross;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bomb_col_q <= '0;
      bomb_row_q <= '0;
      c_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bomb_col_q <= bomb_col_d;
      bomb_row_q <= bomb_row_d;
      c_q        <= C;
    end
  end

  // Status flags follow the state register; pixel enables lag the scan by one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bomb_on_q  <= 1'b0;
      expl_on_q  <= 1'b0;
      bomb_rgb_q <= '0;
      expl_rgb_q <= '0;
      hit_q      <= 1'b0;
      bomb_act_q <= 1'b0;
      expl_act_q <= 1'b0;
    end else begin
      bomb_on_q  <= bomb_on_d;
      expl_on_q  <= expl_on_d;
      bomb_rgb_q <= bomb_on_d ? BOMB_RGB : 12'h000;
      expl_rgb_q <= expl_on_d ? EXPLOSION_RGB : 12'h000;
      hit_q      <= hit_d;
      bomb_act_q <= (state_d == ARMED);
      expl_act_q <= (state_d == EXPLODE);
    end
  end

  assign bomb_on        = bomb_on_q;
  assign bomb_rgb       = bomb_rgb_q;
  assign explosion_on   = expl_on_q;
  assign explosion_rgb  = expl_rgb_q;
  assign bomb_active    = bomb_act_q;
  assign explode_active = expl_act_q;
  assign bomberman_hit  = hit_q;

endmodule

// File: tb/tb_bomb_controller.sv
// Directed + randomized bench for bomb_controller against an abstract game model.
module tb_bomb_controller;

  localparam int FUSE = 20;
  localparam int EXPL = 10;

  logic        clk = 1'b0;
  logic        reset, C, game_over;
  logic [9:0]  b_x, b_y, v_x, v_y;
  logic        bomb_on, explosion_on, bomb_active, explode_active, bomberman_hit;
  logic [11:0] bomb_rgb, explosion_rgb;

  always #5 clk = ~clk;

  bomb_controller #(.FUSE_CYCLES(FUSE), .EXPLODE_CYCLES(EXPL)) dut (
    .clk(clk), .reset(reset), .C(C), .b_x(b_x), .b_y(b_y), .game_over(game_over),
    .v_x(v_x), .v_y(v_y), .bomb_on(bomb_on), .bomb_rgb(bomb_rgb),
    .explosion_on(explosion_on), .explosion_rgb(explosion_rgb),
    .bomb_active(bomb_active), .explode_active(explode_active),
    .bomberman_hit(bomberman_hit)
  );

  // Model: phase 0 = no bomb, 1 = fuse burning, 2 = blast; ticks = cycles spent in phase.
  int m_phase, m_ticks, m_bc, m_br;
  bit m_c;
  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int player_tile(input int p, input int off, input int lim);
    int t;
    t = ((p - off + 16) & 1023) / 32;
    return (t > lim - 1) ? lim - 1 : t;
  endfunction

  function automatic bit blast_covers(input int c, input int r);
    if (c < 0 || c > 19 || r < 0 || r > 14) return 0;
    return (r == m_br && c >= m_bc - 1 && c <= m_bc + 1) ||
           (c == m_bc && r >= m_br - 1 && r <= m_br + 1);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ticks = 0; m_bc = 0; m_br = 0; m_c = 0;
  endtask

  task automatic step();
    int vx, vy, pc, pr, px, py;
    bit vis, e_bon, e_eon, e_hit, place;
    vx = int'(v_x); vy = int'(v_y);
    vis = vx >= 144 && vx <= 783 && vy >= 35 && vy <= 514;
    pc = (vx - 144) / 32; pr = (vy - 35) / 32;
    px = (vx - 144) % 32; py = (vy - 35) % 32;
    e_bon = m_phase == 1 && vis && pc == m_bc && pr == m_br &&
            px >= 4 && px <= 27 && py >= 4 && py <= 27;
    e_eon = m_phase == 2 && vis && blast_covers(pc, pr);
    e_hit = m_phase == 2 && blast_covers(player_tile(int'(b_x), 144, 20), player_tile(int'(b_y), 35, 15));
    place = C && !m_c;
    @(posedge clk);
    m_c = C;
    if (!game_over) begin
      if (m_phase == 0) begin
        if (place) begin
          m_bc = player_tile(int'(b_x), 144, 20);
          m_br = player_tile(int'(b_y), 35, 15);
          m_phase = 1; m_ticks = 0;
        end
      end else begin
        m_ticks++;
        if (m_phase == 1 && m_ticks == FUSE) begin m_phase = 2; m_ticks = 0; end
        else if (m_phase == 2 && m_ticks == EXPL) begin m_phase = 0; m_ticks = 0; end
      end
    end
    #1;
    check("bomb_on", bomb_on, e_bon);
    check("bomb_rgb", bomb_rgb, e_bon ? 32'h222 : 32'h0);
    check("explosion_on", explosion_on, e_eon);
    check("explosion_rgb", explosion_rgb, e_eon ? 32'hF80 : 32'h0);
    check("hit", bomberman_hit, e_hit);
    check("bomb_active", bomb_active, m_phase == 1);
    check("explode_active", explode_active, m_phase == 2);
  endtask

  task automatic rand_pix();
    v_x = 10'($urandom_range(0, 799));
    v_y = 10'($urandom_range(0, 524));
  endtask

  task automatic place_at(input int bx, input int by);
    b_x = 10'(bx); b_y = 10'(by); C = 1'b1;
    step();
    C = 1'b0;
  endtask

  task automatic wait_phase(input int target, input int bound);
    int n;
    n = 0;
    while (m_phase != target && n < bound) begin rand_pix(); step(); n++; end
    if (m_phase != target) begin
      checks++; errors++;
      $error("FAIL wait_phase: model phase %0d expected %0d", m_phase, target);
    end
  endtask

  task automatic tile_centre(input int c, input int r);
    v_x = 10'(144 + c * 32 + 16);
    v_y = 10'(35 + r * 32 + 16);
  endtask

  initial begin
    int n;
    reset = 1'b1; C = 1'b0; game_over = 1'b0;
    b_x = '0; b_y = '0; v_x = '0; v_y = '0;
    model_reset();
    #1;
    check("rst_bomb_on", bomb_on, 0);
    check("rst_expl_on", explosion_on, 0);
    check("rst_bomb_rgb", bomb_rgb, 0);
    check("rst_expl_rgb", explosion_rgb, 0);
    check("rst_active", {bomb_active, explode_active, bomberman_hit}, 0);
    #12 reset = 1'b0;

    // Bomb at tile (1,1): exact 24x24 inset, timers frozen while sweeping.
    place_at(176, 67);
    check("armed_after_place", bomb_active, 1);
    game_over = 1'b1;
    v_y = 10'd80;
    for (int x = 170; x <= 215; x++) begin
      v_x = 10'(x); step();
      check("bomb_hwin", bomb_on, (x >= 180 && x <= 203));
    end
    v_x = 10'd190;
    for (int y = 60; y <= 100; y++) begin
      v_y = 10'(y); step();
      check("bomb_vwin", bomb_on, (y >= 71 && y <= 94));
    end
    repeat (100) begin rand_pix(); step(); end
    game_over = 1'b0;
    n = 0;
    while (!explode_active && n < 100) begin rand_pix(); step(); n++; end
    check("fuse_len", n, FUSE);
    game_over = 1'b1;
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 20; c++) begin
        tile_centre(c, r); step();
        check("cross_11", explosion_on, (r == 1 && c <= 2) || (c == 1 && r <= 2));
      end
    game_over = 1'b0;
    n = 0;
    while (explode_active && n < 100) begin rand_pix(); step(); n++; end
    check("explode_len", n, EXPL);

    // Corner bomb: arms clipped at the grid edge, left margin dark.
    place_at(144, 35);
    wait_phase(2, 50);
    game_over = 1'b1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        tile_centre(c, r); step();
        check("cross_00", explosion_on, (r == 0 && c <= 1) || (c == 0 && r <= 1));
      end
    repeat (20) begin
      v_x = 10'($urandom_range(0, 143)); v_y = 10'($urandom_range(35, 120)); step();
      check("left_margin", explosion_on, 0);
    end
    game_over = 1'b0;
    wait_phase(0, 50);

    // Extra edge in ARMED and C held across EXPLODE->IDLE never re-place.
    place_at(176, 67);
    repeat (3) begin rand_pix(); step(); end
    b_x = 10'd304; b_y = 10'd195;
    C = 1'b1; step(); C = 1'b0; step();
    tile_centre(1, 1); step(); step();
    check("ignored_edge", bomb_on, 1);
    C = 1'b1;
    wait_phase(2, 50);
    wait_phase(0, 50);
    repeat (5) begin rand_pix(); step(); end
    check("held_c_idle", bomb_active, 0);
    C = 1'b0; step();
    C = 1'b1; step();
    check("fresh_edge", bomb_active, 1);
    C = 1'b0;
    tile_centre(5, 5); step(); step();
    check("new_tile", bomb_on, 1);
    wait_phase(0, 60);

    // Player inside and outside the blast.
    place_at(176, 67);
    wait_phase(2, 50);
    b_x = 10'd192; b_y = 10'd51; step(); step();
    check("hit_in", bomberman_hit, 1);
    b_y = 10'd83; step(); step();
    check("hit_out", bomberman_hit, 0);
    wait_phase(0, 50);

    // Freeze mid-fuse for 15 cycles.
    place_at(176, 67);
    n = 0;
    repeat (5) begin rand_pix(); step(); n++; end
    game_over = 1'b1;
    repeat (15) begin rand_pix(); step(); n++; end
    game_over = 1'b0;
    while (!explode_active && n < 200) begin rand_pix(); step(); n++; end
    check("frozen_fuse_len", n, FUSE + 15);
    wait_phase(0, 50);

    // Random soak focused on the upper-left play area.
    repeat (800) begin
      if ($urandom_range(0, 3) == 0) C = ~C;
      game_over = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) begin
        b_x = 10'($urandom_range(90, 420)); b_y = 10'($urandom_range(0, 300));
      end
      v_x = 10'($urandom_range(100, 420)); v_y = 10'($urandom_range(0, 300));
      step();
    end
    C = 1'b0; game_over = 1'b0;
    wait_phase(0, 60);

    // Async reset in the middle of a blast.
    place_at(176, 67);
    wait_phase(2, 50);
    b_x = 10'd176; b_y = 10'd67;
    tile_centre(1, 1); step();
    check("pre_rst_expl", explosion_on, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_expl_on", explosion_on, 0);
    check("arst_expl_rgb", explosion_rgb, 0);
    check("arst_flags", {bomb_on, bomb_active, explode_active, bomberman_hit}, 0);
    model_reset();
    #4 reset = 1'b0;
    repeat (20) begin rand_pix(); step(); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
